// File: rtl/axi_adapter_req_arbiter_pkg.sv
// Shared types and FSM encodings for the axi_adapter request arbiter.
// Imported by the arbiter, its round-robin picker and the adapter interface.
package axi_adapter_req_arbiter_pkg;

  typedef enum logic {
    SINGLE_REQ     = 1'b0,
    CACHE_LINE_REQ = 1'b1
  } ad_req_t;

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_LR   = 4'd1,
    AMO_SC   = 4'd2,
    AMO_SWAP = 4'd3,
    AMO_ADD  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_XOR  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MAXU = 4'd9,
    AMO_MIN  = 4'd10,
    AMO_MINU = 4'd11,
    AMO_CAS1 = 4'd12,
    AMO_CAS2 = 4'd13
  } amo_t;

  typedef logic [1:0] arb_state_e;

  localparam arb_state_e ST_IDLE  = 2'd0;
  localparam arb_state_e ST_ISSUE = 2'd1;
  localparam arb_state_e ST_WAIT  = 2'd2;

endpackage

// File: rtl/axi_adapter_req_arbiter_if.sv
// Request/response bundle between the arbiter and axi_adapter.
// master = arbiter side, slave = adapter side.
interface axi_adapter_req_arbiter_if
  import axi_adapter_req_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned AXI_ID_WIDTH = 4
);

  logic                      adp_req_o;
  ad_req_t                   adp_type_o;
  amo_t                      adp_amo_o;
  logic [ADDR_WIDTH-1:0]     adp_addr_o;
  logic                      adp_we_o;
  logic [DATA_WIDTH-1:0]     adp_wdata_o;
  logic [DATA_WIDTH/8-1:0]   adp_be_o;
  logic [1:0]                adp_size_o;
  logic [AXI_ID_WIDTH-1:0]   adp_id_o;
  logic                      adp_gnt_i;
  logic                      adp_valid_i;
  logic [DATA_WIDTH-1:0]     adp_rdata_i;
  logic [AXI_ID_WIDTH-1:0]   adp_id_i;

  modport master (
    output adp_req_o, adp_type_o, adp_amo_o,
    output adp_addr_o, adp_we_o, adp_wdata_o,
    output adp_be_o, adp_size_o, adp_id_o,
    input  adp_gnt_i, adp_valid_i,
    input  adp_rdata_i, adp_id_i
  );

  modport slave (
    input  adp_req_o, adp_type_o, adp_amo_o,
    input  adp_addr_o, adp_we_o, adp_wdata_o,
    input  adp_be_o, adp_size_o, adp_id_o,
    output adp_gnt_i, adp_valid_i,
    output adp_rdata_i, adp_id_i
  );

endinterface

// File: rtl/axi_adapter_req_arbiter_rr_arb_onehot.sv
// Combinational round-robin pick: first request at or after ptr_i,
// wrapping modulo NR_PORTS; returns one-hot grant and its index.
module rr_arb_onehot #(
  parameter int unsigned NR_PORTS = 3,
  parameter int unsigned IDX_W    = $clog2(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [NR_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                any_o
);

  localparam logic [IDX_W:0] NP = (IDX_W+1)'(NR_PORTS);

  logic [IDX_W:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      // ptr_i + i < 2*NR_PORTS, so one subtract wraps it
      pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (pos >= NP) pos = pos - NP;
      if (!any_o && req_i[pos[IDX_W-1:0]]) begin
        any_o                  = 1'b1;
        gnt_o[pos[IDX_W-1:0]]  = 1'b1;
        idx_o                  = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_adapter_req_arbiter.sv
// Round-robin arbiter of NR_PORTS requesters onto a single axi_adapter,
// one transaction in flight, response routed back to the issuing port.
module axi_adapter_req_arbiter
  import axi_adapter_req_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS       = 3,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH     = 64
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NR_PORTS-1:0]                      req_i,
  output logic [NR_PORTS-1:0]                      gnt_o,
  input  ad_req_t [NR_PORTS-1:0]                   type_i,
  input  amo_t [NR_PORTS-1:0]                      amo_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]      addr_i,
  input  logic [NR_PORTS-1:0]                      we_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]      wdata_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]    be_i,
  input  logic [NR_PORTS-1:0][1:0]                 size_i,
  input  logic [NR_PORTS-1:0][AXI_ID_WIDTH-1:0]    id_i,
  output logic [NR_PORTS-1:0]                      valid_o,
  output logic [DATA_WIDTH-1:0]                    rdata_o,
  output logic [AXI_ID_WIDTH-1:0]                  id_o,
  axi_adapter_req_arbiter_if.master                adp
);

  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  if (DATA_WIDTH % AXI_DATA_WIDTH != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of AXI_DATA_WIDTH");
  end
  if (NR_PORTS < 2) begin : g_bad_np
    $error("NR_PORTS must be at least 2");
  end

  typedef struct packed {
    ad_req_t                 typ;
    amo_t                    amo;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic [1:0]              size;
    logic [AXI_ID_WIDTH-1:0] id;
  } req_t;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  req_t             req_q, req_d;

  logic [NR_PORTS-1:0] pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  rr_arb_onehot #(
    .NR_PORTS (NR_PORTS),
    .IDX_W    (IDX_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    req_d    = req_q;
    gnt_o    = '0;
    valid_o  = '0;
    rdata_o  = '0;
    id_o     = '0;
    unique case (state_q)
      ST_IDLE: begin
        // gnt_o is combinational on req_i, so keep it quiet under reset
        if (pick_any && !rst_i) begin
          gnt_o       = pick_gnt;
          win_d       = pick_idx;
          req_d.typ   = type_i[pick_idx];
          req_d.amo   = amo_i[pick_idx];
          req_d.addr  = addr_i[pick_idx];
          req_d.we    = we_i[pick_idx];
          req_d.wdata = wdata_i[pick_idx];
          req_d.be    = be_i[pick_idx];
          req_d.size  = size_i[pick_idx];
          req_d.id    = id_i[pick_idx];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (adp.adp_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (adp.adp_valid_i) begin
          valid_o[win_q] = 1'b1;
          rdata_o        = adp.adp_rdata_i;
          id_o           = adp.adp_id_i;
          rr_ptr_d       = (win_q == IDX_W'(NR_PORTS-1))
                           ? '0 : win_q + IDX_W'(1);
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      req_q    <= req_d;
    end
  end

  assign adp.adp_req_o   = (state_q == ST_ISSUE);
  assign adp.adp_type_o  = req_q.typ;
  assign adp.adp_amo_o   = req_q.amo;
  assign adp.adp_addr_o  = req_q.addr;
  assign adp.adp_we_o    = req_q.we;
  assign adp.adp_wdata_o = req_q.wdata;
  assign adp.adp_be_o    = req_q.be;
  assign adp.adp_size_o  = req_q.size;
  assign adp.adp_id_o    = req_q.id;

  // a response outside WAIT has no owner and is dropped
  a_rsp_in_wait: assert property (
    @(posedge clk_i) disable iff (rst_i)
    adp.adp_valid_i |-> state_q == ST_WAIT
  ) else $warning("adp_valid_i outside WAIT ignored");

endmodule

// File: doc/axi_adapter_req_arbiter.md
Name: axi_adapter_req_arbiter

Overview:
Arbitrates NR_PORTS cache/PTW request ports onto the single req/gnt/valid interface of axi_adapter, directly upstream of it.
- Round-robin selection; winning request is registered and held stable until the adapter grants it.
- One transaction outstanding at a time; the response (valid/rdata) is routed back to the port that issued it.

Parameters:
NR_PORTS, 3, number of upstream requesters (2..8)
DATA_WIDTH, 256, request/response data width (matches axi_adapter DATA_WIDTH)
AXI_DATA_WIDTH, 64, adapter beat width; DATA_WIDTH/AXI_DATA_WIDTH beats
AXI_ID_WIDTH, 4, transaction id width
ADDR_WIDTH, 64, request address width (riscv::XLEN)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  NR_PORTS  per-port request
gnt_o  out  NR_PORTS  per-port grant (one-hot or zero)
type_i  in  NR_PORTS x ad_req_t  SINGLE_REQ / CACHE_LINE_REQ
amo_i  in  NR_PORTS x amo_t  atomic op
addr_i  in  NR_PORTS x ADDR_WIDTH  address
we_i  in  NR_PORTS  write enable
wdata_i  in  NR_PORTS x DATA_WIDTH  write data
be_i  in  NR_PORTS x DATA_WIDTH/8  byte enables
size_i  in  NR_PORTS x 2  access size
id_i  in  NR_PORTS x AXI_ID_WIDTH  transaction id
valid_o  out  NR_PORTS  per-port response valid (one-hot or zero)
rdata_o  out  DATA_WIDTH  response data, broadcast to all ports
id_o  out  AXI_ID_WIDTH  response id, broadcast
adp_req_o / adp_type_o / adp_amo_o / adp_addr_o / adp_we_o / adp_wdata_o / adp_be_o / adp_size_o / adp_id_o  out  as above  request to axi_adapter
adp_gnt_i  in  1  adapter grant
adp_valid_i  in  1  adapter response valid
adp_rdata_i  in  DATA_WIDTH  adapter response data
adp_id_i  in  AXI_ID_WIDTH  adapter response id

Behaviour:
- Reset (rst_i=1, async): state=IDLE, rr_ptr=0, all outputs 0 (gnt_o, valid_o, adp_req_o, all adp_* fields, rdata_o, id_o).
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_i is set, select the first set bit at or after rr_ptr, wrapping modulo NR_PORTS.
  - Assert gnt_o[winner] combinationally in the same cycle.
  - Capture all of the winner's fields into the request register and winner index; go to ISSUE.
  - If no req_i is set, stay in IDLE with gnt_o=0.
- ISSUE:
  - adp_req_o=1, adp_* driven from the register; held stable while adp_gnt_i=0.
  - gnt_o=0 and req_i is ignored.
  - On adp_gnt_i=1: go to WAIT; adp_req_o drops next cycle.
- WAIT:
  - adp_req_o=0.
  - On adp_valid_i=1: valid_o[winner]=1 for exactly that cycle (combinational pass-through); rdata_o=adp_rdata_i, id_o=adp_id_i.
  - Same cycle: rr_ptr <= (winner+1) mod NR_PORTS; go to IDLE.
- Latency:
  - Grant to port: 0 cycles from req_i in IDLE.
  - Request to adapter: 1 cycle after grant.
  - Response to port: 0 cycles after adp_valid_i.
  - Minimum back-to-back spacing: IDLE→ISSUE→WAIT→IDLE, 3 cycles plus adapter latency.
- Writes complete on adapter valid (B response) exactly like reads; rdata_o content is don't-care for writes.
- adp_valid_i in IDLE/ISSUE is a protocol error: ignored, no valid_o, flagged by an assertion.
- A port deasserting req_i after its grant has no effect; the request is already captured.
- rr_ptr updates only on response completion, not on grant.
- Reset mid-operation returns to IDLE and abandons the in-flight transaction; axi_adapter must be reset in the same cycle.
- Width checks (elaboration assertions): DATA_WIDTH % AXI_DATA_WIDTH == 0; NR_PORTS >= 2.

Decomposition:
- ariane_axi package: ad_req_t (existing) and a new arb_state_e enum {IDLE, ISSUE, WAIT}.
- ariane_pkg: amo_t (existing).
- One sub-module, rr_arb_onehot: pure combinational round-robin priority pick (req vector, rr_ptr) → one-hot grant and index.
- FSM and request register live in the top.

Test Plan:
- Single port: req_i=3'b010, addr=0x8000_1000, we=0, CACHE_LINE_REQ → gnt_o=3'b010 same cycle; adp_req_o=1 next cycle with addr 0x8000_1000; after adp_valid_i with rdata=256'hA5.., valid_o=3'b010 for one cycle and rdata_o matches.
- Contention: req_i=3'b111 held continuously across 3 transactions from reset → grant order port0, port1, port2; rr_ptr=0 after the third response.
- Grant stall: adp_gnt_i held 0 for 5 cycles → adp_req_o and all adp_* fields stable for 5 cycles; upstream gnt_o=0 throughout, port req_i changes ignored.
- Write: port2 we=1, be=32'hFFFF_FFFF, wdata=0x0123.. → adp_we_o=1 with identical wdata/be; valid_o=3'b100 on adp_valid_i.
- Async reset in WAIT: rst_i pulsed mid-cycle → all outputs 0 immediately, state IDLE, rr_ptr=0; a later adp_valid_i produces no valid_o.
- Spurious response: adp_valid_i=1 in IDLE → valid_o stays 0, assertion fires.
